// File: rtl/mrs_8_arb_pkg.sv
// Shared encodings and widths for the two-port shifter arbiter and its datapath.
package mrs_8_arb_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SHR = 2'b10;
    localparam logic [1:0] MODE_SHL = 2'b11;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mrs_8_arb_shifter.sv
// mrs_8: combinational 8-bit masking rotating shifter (rotate/logical shift, either direction).
module mrs_8
    import mrs_8_arb_pkg::*;
(
    input  logic [DATA_W-1:0] mrsdata,
    input  logic [AMT_W-1:0]  mrssel,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] mrsout
);

    logic [AMT_W:0]    inv_sel;
    logic [DATA_W-1:0] shr_v;
    logic [DATA_W-1:0] shl_v;

    // Shifting by 8 empties the 8-bit value, so amount 0 leaves rotates unchanged.
    always_comb begin
        inv_sel = 4'd8 - {1'b0, mrssel};
        shr_v   = mrsdata >> mrssel;
        shl_v   = mrsdata << mrssel;
        mrsout  = mrsdata;
        case (mode)
            MODE_ROR: mrsout = shr_v | (mrsdata << inv_sel);
            MODE_ROL: mrsout = shl_v | (mrsdata >> inv_sel);
            MODE_SHR: mrsout = shr_v;
            MODE_SHL: mrsout = shl_v;
            default:  mrsout = mrsdata;
        endcase
    end

endmodule

// File: rtl/mrs_8_arb.sv
// Two-port arbiter feeding one shared mrs_8 shifter, with a one-entry registered result stage.
//   state    | meaning
//   ST_EMPTY | no result held, r_valid = 0
//   ST_FULL  | result held in r_data/r_src, r_valid = 1
module mrs_8_arb
    import mrs_8_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_data,
    input  logic [AMT_W-1:0]  a_amt,
    input  logic [1:0]        a_mode,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic [AMT_W-1:0]  b_amt,
    input  logic [1:0]        b_mode,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_src
);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;
    logic              prio_q, prio_d;

    logic              grant_a, grant_b, can_accept, accept;
    logic [DATA_W-1:0] g_data;
    logic [AMT_W-1:0]  g_amt;
    logic [1:0]        g_mode;
    logic [DATA_W-1:0] shift_out;

    always_comb begin
        grant_b    = b_valid & (~a_valid | (FAIR & prio_q));
        grant_a    = a_valid & ~grant_b;
        can_accept = (state_q == ST_EMPTY) | r_ready;
        a_ready    = grant_a & can_accept & ~rst;
        b_ready    = grant_b & can_accept & ~rst;
        accept     = a_ready | b_ready;
        g_data     = grant_b ? b_data : a_data;
        g_amt      = grant_b ? b_amt  : a_amt;
        g_mode     = grant_b ? b_mode : a_mode;
    end

    mrs_8 u_mrs_8 (
        .mrsdata (g_data),
        .mrssel  (g_amt),
        .mode    (g_mode),
        .mrsout  (shift_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        prio_d  = prio_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (r_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            data_d = shift_out;
            src_d  = b_ready ? SRC_B : SRC_A;
            // Pointer hands preference to whichever side just lost.
            if (FAIR) prio_d = a_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= SRC_A;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            prio_q  <= prio_d;
        end
    end

    assign r_valid = (state_q == ST_FULL);
    assign r_data  = data_q;
    assign r_src   = src_q;

endmodule

// File: tb/tb_mrs_8_arb.sv
// Directed bench for mrs_8_arb: op table plus arbitration, backpressure and reset sequences.
module tb_mrs_8_arb;

    logic       clk, rst;
    logic       a_valid, b_valid, r_ready;
    logic [7:0] a_data, b_data;
    logic [2:0] a_amt, b_amt;
    logic [1:0] a_mode, b_mode;
    logic       a_ready, b_ready, r_valid, r_src;
    logic [7:0] r_data;
    logic       fa_ready, fb_ready, f_valid, f_src;
    logic [7:0] f_data;

    int n_cmp = 0;
    int n_err = 0;

    mrs_8_arb #(.FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_mode(a_mode),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_mode(b_mode),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_src(r_src)
    );

    mrs_8_arb #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(fa_ready), .a_data(a_data), .a_amt(a_amt), .a_mode(a_mode),
        .b_valid(b_valid), .b_ready(fb_ready), .b_data(b_data), .b_amt(b_amt), .b_mode(b_mode),
        .r_valid(f_valid), .r_ready(r_ready), .r_data(f_data), .r_src(f_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'hB4, 3'd3, 2'b00, 8'h96};
        vecs[1]  = '{8'hB4, 3'd3, 2'b01, 8'hA5};
        vecs[2]  = '{8'hB4, 3'd3, 2'b10, 8'h16};
        vecs[3]  = '{8'hB4, 3'd3, 2'b11, 8'hA0};
        vecs[4]  = '{8'h5C, 3'd0, 2'b00, 8'h5C};
        vecs[5]  = '{8'h5C, 3'd0, 2'b01, 8'h5C};
        vecs[6]  = '{8'h5C, 3'd0, 2'b10, 8'h5C};
        vecs[7]  = '{8'h5C, 3'd0, 2'b11, 8'h5C};
        vecs[8]  = '{8'h81, 3'd7, 2'b00, 8'h03};
        vecs[9]  = '{8'h3C, 3'd4, 2'b01, 8'hC3};
        vecs[10] = '{8'h81, 3'd7, 2'b10, 8'h01};
        vecs[11] = '{8'h81, 3'd1, 2'b11, 8'h02};

        rst = 1'b1;
        a_valid = 0; b_valid = 0; r_ready = 1;
        a_data = 0; a_amt = 0; a_mode = 0;
        b_data = 0; b_amt = 0; b_mode = 0;
        tick();
        do_reset();
        chk("reset_r_valid", r_valid, 0);
        chk("reset_r_data", r_data, 8'h00);
        chk("reset_r_src", r_src, 0);

        // A-only op table, one job per cycle
        for (int i = 0; i < 12; i++) begin
            a_valid = 1; a_data = vecs[i].data; a_amt = vecs[i].amt; a_mode = vecs[i].mode;
            #1;
            chk("tbl_a_ready", a_ready, 1);
            tick();
            chk("tbl_r_valid", r_valid, 1);
            chk("tbl_r_data", r_data, vecs[i].exp);
            chk("tbl_r_src", r_src, 0);
        end
        a_valid = 0;
        tick();
        chk("drain_empty", r_valid, 0);

        // Round-robin with both valid
        do_reset();
        a_valid = 1; a_data = 8'hB4; a_amt = 3'd3; a_mode = 2'b00;
        b_valid = 1; b_data = 8'h5C; b_amt = 3'd0; b_mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk("rr_r_valid", r_valid, 1);
            chk("rr_r_src", r_src, (i % 2 == 0) ? 0 : 1);
            chk("rr_r_data", r_data, (i % 2 == 0) ? 8'h96 : 8'h5C);
        end

        // Backpressure: hold the B result for 3 cycles
        r_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_a_ready", a_ready, 0);
            chk("bp_b_ready", b_ready, 0);
            tick();
            chk("bp_r_valid", r_valid, 1);
            chk("bp_r_data", r_data, 8'h5C);
            chk("bp_r_src", r_src, 1);
        end
        r_ready = 1;
        #1;
        chk("bp_release_a_ready", a_ready, 1);
        chk("bp_release_b_ready", b_ready, 0);
        tick();
        chk("bp_reload_r_valid", r_valid, 1);
        chk("bp_reload_r_data", r_data, 8'h96);
        chk("bp_reload_r_src", r_src, 0);

        // Fixed priority: B starves
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_a_ready", fa_ready, 1);
            chk("fp_b_ready", fb_ready, 0);
            tick();
            chk("fp_r_src", f_src, 0);
            chk("fp_r_data", f_data, 8'h96);
        end

        // Reset while full with prio pointing at B
        do_reset();
        #1;
        chk("pre_a_ready", a_ready, 1);
        tick();
        chk("pre_r_valid", r_valid, 1);
        do_reset();
        chk("post_rst_r_valid", r_valid, 0);
        chk("post_rst_r_data", r_data, 8'h00);
        chk("post_rst_r_src", r_src, 0);
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        tick();
        chk("post_rst_src", r_src, 0);

        a_valid = 0; b_valid = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
